prog_instr_memory: RTL

PROG_INSTR_MEMORY -- requirements
Module: prog_instr_memory

---
 rtl/prog_instr_memory_pkg.sv | 13 +
 rtl/prog_instr_memory_if.sv | 40 ++++
 rtl/prog_instr_memory_imem_ram.sv | 36 +++
 rtl/prog_instr_memory.sv | 122 ++++++++++++
 4 files changed

// File: rtl/prog_instr_memory_pkg.sv
// Shared processor package for the instruction memory: load FSM encoding and
// the default word returned for out-of-range fetches.
package prog_instr_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ERR  = 2'd2
  } load_state_e;

  localparam logic [15:0] NOP_WORD_DEF = 16'h0000;

endpackage

// File: rtl/prog_instr_memory_if.sv
// Load-session and fetch bus of the instruction memory.
// The master side is the loader/fetcher; the slave side is the memory.
interface prog_instr_memory_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_busy;
  logic              load_done;
  logic              load_err;
  logic [CNT_W-1:0]  load_count;

  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              fetch_err;

  modport master (
    output load_start, load_base, load_valid, load_data, load_last,
    output fetch_en, fetch_addr,
    input  load_ready, load_busy, load_done, load_err, load_count,
    input  fetch_data, fetch_valid, fetch_err
  );

  modport slave (
    input  load_start, load_base, load_valid, load_data, load_last,
    input  fetch_en, fetch_addr,
    output load_ready, load_busy, load_done, load_err, load_count,
    output fetch_data, fetch_valid, fetch_err
  );
endinterface

// File: rtl/prog_instr_memory_imem_ram.sv
// Instruction storage: one write port, one registered write-first read port.
// Only the read register is reset; the array keeps its contents across rst.
module imem_ram
  import prog_instr_memory_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register holds between reads so the fetch result stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/prog_instr_memory.sv
// Program instruction memory: load-session FSM writing sequential words from a
// base address, plus a 1-cycle fetch port with out-of-range NOP substitution.
module prog_instr_memory
  import prog_instr_memory_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 256,
  parameter int                ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
  input logic               clk,
  input logic               rst,
  prog_instr_memory_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AW    = $clog2(DEPTH);

  load_state_e       state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              fetch_vld_q;
  logic              fetch_oor_q;
  logic [DATA_W-1:0] ram_rdata;

  logic accept;
  logic base_ok;
  logic fetch_ok;

  assign base_ok  = bus.load_base  < ADDR_W'(DEPTH);
  assign fetch_ok = bus.fetch_addr < ADDR_W'(DEPTH);
  assign accept   = bus.load_valid && (state_q == ST_LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        // load_start is deliberately not looked at while a session is open.
        if (accept) begin
          ptr_d = ptr_q + AW'(1);
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.load_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (ptr_q == AW'(DEPTH - 1)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        if (bus.load_start) begin
          if (base_ok) begin
            state_d = ST_LOAD;
            ptr_d   = bus.load_base[AW-1:0];
            cnt_d   = '0;
            err_d   = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
    endcase
  end

  // Range flag is kept alongside the read register so data holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_vld_q <= 1'b0;
      fetch_oor_q <= 1'b0;
    end else begin
      fetch_vld_q <= bus.fetch_en;
      if (bus.fetch_en) fetch_oor_q <= !fetch_ok;
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (accept),
    .waddr_i (ptr_q),
    .wdata_i (bus.load_data),
    .re_i    (bus.fetch_en && fetch_ok),
    .raddr_i (bus.fetch_addr[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign bus.load_ready  = (state_q == ST_LOAD);
  assign bus.load_busy   = (state_q == ST_LOAD);
  assign bus.load_done   = done_q;
  assign bus.load_err    = err_q;
  assign bus.load_count  = cnt_q;
  assign bus.fetch_valid = fetch_vld_q;
  assign bus.fetch_err   = fetch_vld_q && fetch_oor_q;
  assign bus.fetch_data  = fetch_oor_q ? NOP_WORD : ram_rdata;
endmodule
